// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: register-file write port owner; zero-init, then mem-priority writeback with ALU FIFO.
// Optional WB_FORWARD_EN adds a combinational forwarding lookup (fwd_addr/fwd_hit/fwd_data).
module regfile_wb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int ALU_FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [ADDR_W-1:0]                 alu_addr,
  input  logic [DATA_W-1:0]                 alu_data,
  input  logic                              mem_valid,
  output logic                              mem_ready,
  input  logic [ADDR_W-1:0]                 mem_addr,
  input  logic [DATA_W-1:0]                 mem_data,
  output logic                              write_enable,
  output logic [ADDR_W-1:0]                 write_addr,
  output logic [DATA_W-1:0]                 write_data,
  output logic                              init_done,
  output logic [$clog2(ALU_FIFO_DEPTH):0]   fifo_count
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]                 fwd_addr,
  output logic                              fwd_hit,
  output logic [DATA_W-1:0]                 fwd_data
`endif
);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = ADDR_W + 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [IW-1:0] init_cnt;
  logic [PW-1:0] wptr, rptr;
  logic [ALU_FIFO_DEPTH-1:0] kill;
  logic [ADDR_W-1:0] fifo_addr [ALU_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [ALU_FIFO_DEPTH];
  logic run, init_wr, mem_acc, push, pop, stg_en;
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_data;
  assign run = state == RUN;
  assign init_done = run;
  assign mem_ready = run;
  assign alu_ready = run && fifo_count != CW'(ALU_FIFO_DEPTH);
  always_comb begin
    init_wr = !run && init_cnt < IW'(NUM_REGS);
    state_n = (!run && !init_wr) ? RUN : state;
    mem_acc = run && mem_valid;
    push = run && alu_valid && alu_ready && alu_addr != '0;
    pop = run && !mem_valid && fifo_count != '0;
    stg_en = init_wr || (mem_acc && mem_addr != '0) || (pop && !kill[rptr]);
    stg_addr = init_wr ? init_cnt[ADDR_W-1:0] : mem_valid ? mem_addr : fifo_addr[rptr];
    stg_data = init_wr ? '0 : mem_valid ? mem_data : fifo_data[rptr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      init_cnt <= IW'(1);
      write_enable <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      kill <= '0;
    end else begin
      state <= state_n;
      init_cnt <= init_wr ? init_cnt + IW'(1) : init_cnt;
      write_enable <= stg_en;
      if (stg_en) begin
        write_addr <= stg_addr;
        write_data <= stg_data;
      end
      wptr <= push ? wptr + PW'(1) : wptr;
      rptr <= pop ? rptr + PW'(1) : rptr;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      // an older queued ALU write to the same reg would clobber the newer load
      for (int i = 0; i < ALU_FIFO_DEPTH; i++)
        if (mem_acc && fifo_addr[i] == mem_addr) kill[i] <= 1'b1;
      if (push) kill[wptr] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= alu_addr;
      fifo_data[wptr] <= alu_data;
    end
  end
`ifdef WB_FORWARD_EN
  logic [PW-1:0] idx;
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    idx = rptr;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < fifo_count && !kill[idx] && fifo_addr[idx] == fwd_addr) begin
        fwd_hit = 1'b1;
        fwd_data = fifo_data[idx];
      end
    end
    if (stg_en && stg_addr == fwd_addr) begin
      fwd_hit = 1'b1;
      fwd_data = stg_data;
    end
    if (fwd_addr == '0) begin
      fwd_hit = 1'b0;
      fwd_data = '0;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vector table plus hand sequences for init, FIFO fill, kill and reset.
module tb_regfile_wb_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0] alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, write_enable, init_done;
  logic [4:0] write_addr;
  logic [31:0] write_data;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .init_done(init_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic we; logic [4:0] wa; logic [31:0] wd; logic [2:0] cnt;
  } vec_t;
  vec_t vt [11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input string name, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    chk({name, ".we"}, 32'(write_enable), 32'(we));
    chk({name, ".addr"}, 32'(write_addr), 32'(wa));
    chk({name, ".data"}, write_data, wd);
  endtask

  initial begin
    vt[0]  = '{1, 5'd5,  32'hAA,   0, 5'd0,  32'h0,  1, 5'd5,  32'hAA,   3'd0};
    vt[1]  = '{1, 5'd9,  32'h1234, 1, 5'd3,  32'h33, 1, 5'd9,  32'h1234, 3'd1};
    vt[2]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  1, 5'd3,  32'h33,   3'd0};
    vt[3]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  0, 5'd3,  32'h33,   3'd0};
    vt[4]  = '{1, 5'd0,  32'hFF,   1, 5'd0,  32'hEE, 0, 5'd3,  32'h33,   3'd0};
    vt[5]  = '{0, 5'd0,  32'h0,    1, 5'd6,  32'h66, 0, 5'd3,  32'h33,   3'd1};
    vt[6]  = '{1, 5'd6,  32'h600,  1, 5'd8,  32'h88, 1, 5'd6,  32'h600,  3'd2};
    vt[7]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  0, 5'd6,  32'h600,  3'd1};
    vt[8]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  1, 5'd8,  32'h88,   3'd0};
    vt[9]  = '{1, 5'd10, 32'hB0,   1, 5'd10, 32'hA0, 1, 5'd10, 32'hB0,   3'd1};
    vt[10] = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,  1, 5'd10, 32'hA0,   3'd0};

    #1;
    chk_wr("reset", 0, 5'd0, 32'h0);
    chk("reset.init_done", 32'(init_done), 0);
    chk("reset.alu_ready", 32'(alu_ready), 0);
    chk("reset.mem_ready", 32'(mem_ready), 0);
    chk("reset.fifo_count", 32'(fifo_count), 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk_wr($sformatf("init%0d", k), 1, 5'(k), 32'h0);
      chk($sformatf("init%0d.done", k), 32'(init_done), 0);
      chk($sformatf("init%0d.rdy", k), 32'({alu_ready, mem_ready}), 0);
    end
    tick();
    chk("init_done", 32'(init_done), 1);
    chk("post_init.we", 32'(write_enable), 0);
    chk("post_init.rdy", 32'({alu_ready, mem_ready}), 32'b11);

    for (int i = 0; i < 11; i++) begin
      mem_valid = vt[i].mv; mem_addr = vt[i].ma; mem_data = vt[i].md;
      alu_valid = vt[i].av; alu_addr = vt[i].aa; alu_data = vt[i].ad;
      tick();
      chk_wr($sformatf("vec%0d", i), vt[i].we, vt[i].wa, vt[i].wd);
      chk($sformatf("vec%0d.cnt", i), 32'(fifo_count), 32'(vt[i].cnt));
    end
    mem_valid = 0; alu_valid = 0;

    // fill FIFO while addr-0 loads hold off pops, then drain in order
    mem_valid = 1; mem_addr = 0;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_addr = 5'(i); alu_data = 32'(i * 'h11);
      chk($sformatf("fill%0d.rdy", i), 32'(alu_ready), 1);
      tick();
      chk($sformatf("fill%0d.cnt", i), 32'(fifo_count), 32'(i));
      chk($sformatf("fill%0d.we", i), 32'(write_enable), 0);
    end
    alu_addr = 5; alu_data = 32'h55;
    chk("full.rdy", 32'(alu_ready), 0);
    tick();
    chk("full.cnt", 32'(fifo_count), 4);
    mem_valid = 0;
    chk("full_pop.rdy", 32'(alu_ready), 0);
    tick();
    chk_wr("drain1", 1, 5'd1, 32'h11);
    chk("drain1.cnt", 32'(fifo_count), 3);
    chk("drain1.rdy", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    chk_wr("drain2", 1, 5'd2, 32'h22);
    chk("drain2.cnt", 32'(fifo_count), 3);
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk_wr($sformatf("drain%0d", k), 1, 5'(k), 32'(k * 'h11));
    end
    chk("drained.cnt", 32'(fifo_count), 0);

    // WAW kill: queued ALU write to 7 superseded by a later load to 7
    mem_valid = 1; mem_addr = 12; mem_data = 32'hC0;
    alu_valid = 1; alu_addr = 7; alu_data = 32'h1;
    tick();
    alu_valid = 0;
    chk_wr("kill_a", 1, 5'd12, 32'hC0);
    mem_addr = 13; mem_data = 32'hD0;
    tick();
    chk_wr("kill_b", 1, 5'd13, 32'hD0);
    mem_addr = 7; mem_data = 32'h2;
    tick();
    mem_valid = 0;
    chk_wr("kill_c", 1, 5'd7, 32'h2);
    chk("kill_c.cnt", 32'(fifo_count), 1);
    tick();
    chk_wr("kill_pop", 0, 5'd7, 32'h2);
    chk("kill_pop.cnt", 32'(fifo_count), 0);
    tick();
    chk("kill_idle.we", 32'(write_enable), 0);

    // reset with three entries pending
    mem_valid = 1; mem_addr = 0;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1; alu_addr = 5'(20 + i); alu_data = 32'(i);
      tick();
    end
    mem_valid = 0; alu_valid = 0;
    chk("pre_rst.cnt", 32'(fifo_count), 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.cnt", 32'(fifo_count), 0);
    chk_wr("mid_rst", 0, 5'd0, 32'h0);
    chk("mid_rst.done", 32'(init_done), 0);
    chk("mid_rst.rdy", 32'({alu_ready, mem_ready}), 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk_wr("reinit1", 1, 5'd1, 32'h0);
    tick();
    chk_wr("reinit2", 1, 5'd2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
